// File: rtl/rca_lsq_routed.sv
// ---------------------------------------------------------------------------
// rca_lsq_routed
//
// Load/store queue between the RCA grid and the shared LSU.
//   * Captures one multi-row request packet per cycle from the grid into a
//     PACKET_DEPTH-entry packet store.
//   * Issues the head packet's rows to the LSU lowest-row-first, one per
//     cycle. The packet pops in the cycle its last row issues.
//   * Tracks outstanding loads with a tag FIFO holding the originating row.
//     Issue is credit-limited to LOAD_DEPTH outstanding loads.
//   * Buffers returning load data in a result FIFO and routes each result to
//     its row with a valid/ready handshake.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   rca_fifo_populated             an RCA is running (feeds rca_lsu_lock)
//   grid_new_request/addr/data/fn3/load/store   per-row request packet
//   grid_fifo_full                 packet store full
//   grid_load_valid/data/ready     per-row load result handshake
//   lsu_ready, lsu_new_request, lsu_rs1/rs2/fn3/load/store   LSU issue
//   lsu_load_complete/data         in-order load return from the LSU
//   rca_lsu_lock                   LSU reserved for the RCA
// ---------------------------------------------------------------------------
module rca_lsq_routed #(
    parameter int NUM_ROWS     = 4,
    parameter int PACKET_DEPTH = 4,
    parameter int LOAD_DEPTH   = 4,
    parameter int XLEN         = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rca_fifo_populated,
    input  logic [NUM_ROWS-1:0]      grid_new_request,
    input  logic [NUM_ROWS*XLEN-1:0] grid_addr,
    input  logic [NUM_ROWS*XLEN-1:0] grid_data,
    input  logic [NUM_ROWS*3-1:0]    grid_fn3,
    input  logic [NUM_ROWS-1:0]      grid_load,
    input  logic [NUM_ROWS-1:0]      grid_store,
    output logic                     grid_fifo_full,
    output logic [NUM_ROWS-1:0]      grid_load_valid,
    output logic [XLEN-1:0]          grid_load_data,
    input  logic [NUM_ROWS-1:0]      grid_load_ready,
    input  logic                     lsu_ready,
    output logic                     lsu_new_request,
    output logic [XLEN-1:0]          lsu_rs1,
    output logic [XLEN-1:0]          lsu_rs2,
    output logic [2:0]               lsu_fn3,
    output logic                     lsu_load,
    output logic                     lsu_store,
    input  logic                     lsu_load_complete,
    input  logic [XLEN-1:0]          lsu_load_data,
    output logic                     rca_lsu_lock
);

    localparam int ROW_W  = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int CNT_W  = $clog2(PACKET_DEPTH + 1);
    localparam int PPTR_W = (PACKET_DEPTH > 1) ? $clog2(PACKET_DEPTH) : 1;
    localparam int OUT_W  = $clog2(LOAD_DEPTH + 1);
    localparam int LPTR_W = (LOAD_DEPTH > 1) ? $clog2(LOAD_DEPTH) : 1;

    // Pointer increments wrap explicitly so non-power-of-two depths work.
    function automatic logic [PPTR_W-1:0] pkt_inc(input logic [PPTR_W-1:0] p);
        return (p == PPTR_W'(PACKET_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [LPTR_W-1:0] ld_inc(input logic [LPTR_W-1:0] p);
        return (p == LPTR_W'(LOAD_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // ------------------------------------------------------------------
    // Packet store
    // ------------------------------------------------------------------
    logic [NUM_ROWS-1:0]      mask_mem  [PACKET_DEPTH];
    logic [NUM_ROWS*XLEN-1:0] addr_mem  [PACKET_DEPTH];
    logic [NUM_ROWS*XLEN-1:0] data_mem  [PACKET_DEPTH];
    logic [NUM_ROWS*3-1:0]    fn3_mem   [PACKET_DEPTH];
    logic [NUM_ROWS-1:0]      load_mem  [PACKET_DEPTH];
    logic [NUM_ROWS-1:0]      store_mem [PACKET_DEPTH];

    logic [PPTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PPTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [NUM_ROWS-1:0] done_q, done_d;

    logic pkt_push;
    logic pkt_pop;

    assign grid_fifo_full = (count_q == CNT_W'(PACKET_DEPTH));
    // An all-zero mask carries no work and is never stored.
    assign pkt_push = (|grid_new_request) & ~grid_fifo_full;

    always_ff @(posedge clk) begin
        if (pkt_push) begin
            mask_mem[wr_ptr_q]  <= grid_new_request;
            addr_mem[wr_ptr_q]  <= grid_addr;
            data_mem[wr_ptr_q]  <= grid_data;
            fn3_mem[wr_ptr_q]   <= grid_fn3;
            load_mem[wr_ptr_q]  <= grid_load;
            store_mem[wr_ptr_q] <= grid_store;
        end
    end

    // ------------------------------------------------------------------
    // Head packet row selection
    // ------------------------------------------------------------------
    logic                head_valid;
    logic [NUM_ROWS-1:0] pending;
    logic [NUM_ROWS-1:0] sel_onehot;
    logic [ROW_W-1:0]    sel;
    logic [XLEN-1:0]     head_addr    [NUM_ROWS];
    logic [XLEN-1:0]     head_data    [NUM_ROWS];
    logic [2:0]          head_fn3     [NUM_ROWS];
    logic [NUM_ROWS-1:0] head_is_load;
    logic [NUM_ROWS*XLEN-1:0] head_addr_w, head_data_w;
    logic [NUM_ROWS*3-1:0]    head_fn3_w;
    logic [NUM_ROWS-1:0]      head_ld_w, head_st_w;

    assign head_valid  = (count_q != '0);
    assign head_addr_w = addr_mem[rd_ptr_q];
    assign head_data_w = data_mem[rd_ptr_q];
    assign head_fn3_w  = fn3_mem[rd_ptr_q];
    assign head_ld_w   = load_mem[rd_ptr_q];
    assign head_st_w   = store_mem[rd_ptr_q];
    assign pending     = head_valid ? (mask_mem[rd_ptr_q] & ~done_q) : '0;
    // Isolate the lowest set bit: that row has priority.
    assign sel_onehot  = pending & ~(pending - 1'b1);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_ROWS; gi++) begin : g_row
            assign head_addr[gi]    = head_addr_w[gi*XLEN +: XLEN];
            assign head_data[gi]    = head_data_w[gi*XLEN +: XLEN];
            assign head_fn3[gi]     = head_fn3_w[gi*3 +: 3];
            // Rows flagged both load and store are treated as stores.
            assign head_is_load[gi] = head_ld_w[gi] & ~head_st_w[gi];
        end
    endgenerate

    always_comb begin
        sel = '0;
        for (int r = NUM_ROWS - 1; r >= 0; r--) begin
            if (pending[r]) sel = ROW_W'(r);
        end
    end

    // ------------------------------------------------------------------
    // Issue
    // ------------------------------------------------------------------
    logic [OUT_W-1:0] outstanding_q, outstanding_d;
    logic             sel_is_load;
    logic             issue;
    logic             load_issue;
    logic             accept;

    assign sel_is_load     = head_is_load[sel];
    assign issue           = (|pending) & lsu_ready &
                             (~sel_is_load | (outstanding_q < OUT_W'(LOAD_DEPTH)));
    assign load_issue      = issue & sel_is_load;
    assign pkt_pop         = issue & ((pending & ~sel_onehot) == '0);

    assign lsu_new_request = issue;
    assign lsu_rs1         = head_addr[sel];
    assign lsu_rs2         = head_data[sel];
    assign lsu_fn3         = head_fn3[sel];
    assign lsu_load        = sel_is_load;
    assign lsu_store       = ~sel_is_load;

    always_comb begin
        wr_ptr_d = pkt_push ? pkt_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pkt_pop  ? pkt_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (pkt_push && !pkt_pop)      count_d = count_q + 1'b1;
        else if (!pkt_push && pkt_pop) count_d = count_q - 1'b1;
        done_d = done_q;
        if (pkt_pop)    done_d = '0;
        else if (issue) done_d = done_q | sel_onehot;
    end

    // ------------------------------------------------------------------
    // Load tag FIFO (occupancy == outstanding) and result FIFO
    // ------------------------------------------------------------------
    logic [ROW_W-1:0]  tag_mem [LOAD_DEPTH];
    logic [XLEN-1:0]   res_mem [LOAD_DEPTH];
    logic [LPTR_W-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
    logic [LPTR_W-1:0] res_wr_q, res_wr_d, res_rd_q, res_rd_d;
    logic [OUT_W-1:0]  res_cnt_q, res_cnt_d;
    logic [ROW_W-1:0]  tag_head;
    logic              deliver_valid;
    logic              res_push;

    // Credits make overflow impossible in normal use; the guard only keeps
    // stray returns after a reset from corrupting the FIFO.
    assign res_push      = lsu_load_complete & (res_cnt_q < OUT_W'(LOAD_DEPTH));
    assign tag_head      = tag_mem[tag_rd_q];
    assign deliver_valid = (outstanding_q != '0) & (res_cnt_q != '0);
    assign accept        = deliver_valid & grid_load_ready[tag_head];
    assign grid_load_data = res_mem[res_rd_q];

    generate
        for (gi = 0; gi < NUM_ROWS; gi++) begin : g_valid
            assign grid_load_valid[gi] = deliver_valid & (tag_head == ROW_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (load_issue) tag_mem[tag_wr_q] <= sel;
        if (res_push)   res_mem[res_wr_q] <= lsu_load_data;
    end

    always_comb begin
        tag_wr_d = load_issue ? ld_inc(tag_wr_q) : tag_wr_q;
        tag_rd_d = accept     ? ld_inc(tag_rd_q) : tag_rd_q;
        res_wr_d = res_push   ? ld_inc(res_wr_q) : res_wr_q;
        res_rd_d = accept     ? ld_inc(res_rd_q) : res_rd_q;
        outstanding_d = outstanding_q;
        if (load_issue && !accept)      outstanding_d = outstanding_q + 1'b1;
        else if (!load_issue && accept) outstanding_d = outstanding_q - 1'b1;
        res_cnt_d = res_cnt_q;
        if (res_push && !accept)      res_cnt_d = res_cnt_q + 1'b1;
        else if (!res_push && accept) res_cnt_d = res_cnt_q - 1'b1;
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            done_q        <= '0;
            outstanding_q <= '0;
            tag_wr_q      <= '0;
            tag_rd_q      <= '0;
            res_wr_q      <= '0;
            res_rd_q      <= '0;
            res_cnt_q     <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            done_q        <= done_d;
            outstanding_q <= outstanding_d;
            tag_wr_q      <= tag_wr_d;
            tag_rd_q      <= tag_rd_d;
            res_wr_q      <= res_wr_d;
            res_rd_q      <= res_rd_d;
            res_cnt_q     <= res_cnt_d;
        end
    end

    assign rca_lsu_lock = (count_q != '0) | (outstanding_q != '0) | rca_fifo_populated;

endmodule
